// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 access sizes,
// bus strobe width and the FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave):
// valid/ready request channel plus a valid-qualified response channel.
interface lsu_if;

  logic                         bus_req_valid;
  logic                         bus_req_ready;
  logic [31:0]                  bus_addr;
  logic                         bus_we;
  logic [lsu_pkg::STRB_W-1:0]   bus_wstrb;
  logic [31:0]                  bus_wdata;
  logic                         bus_rsp_valid;
  logic [31:0]                  bus_rdata;
  logic                         bus_error;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rdata, bus_error
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rdata, bus_error
  );

endinterface

// File: rtl/load_align.sv
// Shifts the addressed byte/halfword of a read word down to bit 0 and
// sign- or zero-extends it according to funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h000000, shifted[7:0]};
      F3_HU:   data = {16'h0000, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Turns one core load/store into a valid/ready bus transaction, stalling the
// core until it completes, faults, times out or is rejected as misaligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        access_fault,
  lsu_if.master       bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state, state_nxt;
  logic              op, is_store, size_ok, align_ok, legal, issue, reject, timeout;
  logic [7:0]        cnt;
  logic              drop;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [31:0]       aligned;
  logic [STRB_W-1:0] strb_nxt;
  logic [31:0]       wdata_nxt;

  load_align u_align (
    .rdata  (bus.bus_rdata),
    .funct3 (funct3_q),
    .offset (off_q),
    .data   (aligned)
  );

  always_comb begin
    op       = mem_read | mem_write;
    is_store = mem_write;
    case (funct3)
      F3_B, F3_H, F3_W: size_ok = 1'b1;
      F3_BU, F3_HU:     size_ok = ~is_store;
      default:          size_ok = 1'b0;
    endcase
    case (funct3)
      F3_H, F3_HU: align_ok = ~address[0];
      F3_W:        align_ok = (address[1:0] == 2'b00);
      default:     align_ok = 1'b1;
    endcase
    legal = size_ok & align_ok;
    // A set misaligned pulse means the core still presents the rejected op.
    issue   = (state == ST_IDLE) & op & legal & ~drop & ~misaligned;
    reject  = (state == ST_IDLE) & op & ~legal & ~misaligned;
    timeout = (state == ST_RESP) & ~bus.bus_rsp_valid & (cnt == TMO_LAST);
    case (funct3)
      F3_B: begin
        strb_nxt  = 4'b0001 << address[1:0];
        wdata_nxt = {4{store_data[7:0]}};
      end
      F3_H: begin
        strb_nxt  = 4'b0011 << {address[1], 1'b0};
        wdata_nxt = {2{store_data[15:0]}};
      end
      default: begin
        strb_nxt  = 4'hF;
        wdata_nxt = store_data;
      end
    endcase
    if (!is_store) begin
      strb_nxt  = '0;
      wdata_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b1;
    case (state)
      ST_IDLE: begin
        stall = op & ~misaligned;
        if (issue) state_nxt = ST_REQ;
      end
      ST_REQ:  if (bus.bus_req_ready) state_nxt = ST_RESP;
      ST_RESP: if (bus.bus_rsp_valid || timeout) state_nxt = ST_DONE;
      ST_DONE: begin
        stall     = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.bus_req_valid = (state == ST_REQ);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_data     <= '0;
      misaligned    <= 1'b0;
      access_fault  <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_we    <= 1'b0;
      bus.bus_wstrb <= '0;
      bus.bus_wdata <= '0;
      funct3_q      <= '0;
      off_q         <= '0;
      cnt           <= '0;
      drop          <= 1'b0;
    end else begin
      misaligned   <= reject;
      access_fault <= 1'b0;
      if (drop && bus.bus_rsp_valid) drop <= 1'b0;
      if (issue) begin
        bus.bus_addr  <= {address[31:2], 2'b00};
        bus.bus_we    <= is_store;
        bus.bus_wstrb <= strb_nxt;
        bus.bus_wdata <= wdata_nxt;
        funct3_q      <= funct3;
        off_q         <= address[1:0];
      end
      if (state == ST_RESP) begin
        if (bus.bus_rsp_valid) begin
          cnt <= '0;
          if (bus.bus_error) begin
            access_fault <= 1'b1;
            if (!bus.bus_we) load_data <= '0;
          end else if (!bus.bus_we) begin
            load_data <= aligned;
          end
        end else if (timeout) begin
          // The abandoned response may still arrive later; drop swallows it.
          cnt          <= '0;
          access_fault <= 1'b1;
          drop         <= 1'b1;
          if (!bus.bus_we) load_data <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses against a byte-level reference model of the access rules.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic [31:0] load_data;
  logic        stall, misaligned, access_fault;

  lsu_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .address      (address),
    .store_data   (store_data),
    .load_data    (load_data),
    .stall        (stall),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ld_model = '0;

  function automatic int acc_size(logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(logic wr, logic [2:0] f3, logic [31:0] addr);
    if (wr) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (addr % acc_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] word);
    longint unsigned base;
    longint          v;
    int              bits, sh;
    base = 64'(word);
    sh   = 8 * int'(addr % 4);
    bits = 8 * acc_size(f3);
    v    = longint'((base >> sh) % (64'd1 << bits));
    if (!f3[2] && bits < 32 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_strb(logic wr, logic [2:0] f3, logic [31:0] addr);
    logic [3:0] s;
    int         off, sz;
    s = '0;
    if (!wr) return s;
    off = int'(addr % 4);
    sz  = acc_size(f3);
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] sd);
    logic [31:0] w;
    int          sz;
    sz = acc_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  // Starts at posedge+1 with the unit idle; returns at posedge+1, idle again.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                            input int ready_dly, input int rsp_dly, input bit err,
                            input int pre_drop, input string tag);
    int          phase, rwait, swait, cyc, drop_left;
    bit          fault_exp;
    logic [31:0] ld_exp;
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; store_data = sd;
    if (!is_legal(wr, f3, addr)) begin
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s rej_stall got %b exp 1", tag, stall); end
      n_checks++; if (bus.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL %s rej_valid0 got %b exp 0", tag, bus.bus_req_valid); end
      @(posedge clock); #1;
      n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL %s misaligned got %b exp 1", tag, misaligned); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s rej_release got %b exp 0", tag, stall); end
      n_checks++; if (bus.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL %s rej_valid1 got %b exp 0", tag, bus.bus_req_valid); end
      n_checks++; if (load_data !== ld_model) begin n_fail++; $display("FAIL %s rej_load got %h exp %h", tag, load_data, ld_model); end
      @(posedge clock); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL %s misaligned_pulse got %b exp 0", tag, misaligned); end
      n_checks++; if (bus.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL %s rej_valid2 got %b exp 0", tag, bus.bus_req_valid); end
      return;
    end
    phase = 0; rwait = 0; swait = 0; cyc = 0; drop_left = pre_drop;
    fault_exp = 1'b0; ld_exp = ld_model;
    while (phase != 3 && cyc < 200) begin
      bus.bus_req_ready = (phase == 1) && (rwait >= ready_dly);
      bus.bus_rsp_valid = ((phase == 2) && rsp_dly >= 0 && swait >= rsp_dly) || (phase == 0 && drop_left == 1);
      bus.bus_error     = bus.bus_rsp_valid && phase == 2 ? err : 1'($urandom);
      bus.bus_rdata     = bus.bus_rsp_valid && phase == 2 ? rdata : $urandom;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s stall_busy cyc %0d got %b exp 1", tag, cyc, stall); end
      n_checks++; if (bus.bus_req_valid !== (phase == 1)) begin n_fail++; $display("FAIL %s req_valid cyc %0d got %b exp %b", tag, cyc, bus.bus_req_valid, phase == 1); end
      n_checks++; if (access_fault !== 1'b0) begin n_fail++; $display("FAIL %s fault_early cyc %0d got %b exp 0", tag, cyc, access_fault); end
      if (phase == 1) begin
        n_checks++; if (bus.bus_addr !== addr - (addr % 4)) begin n_fail++; $display("FAIL %s bus_addr got %h exp %h", tag, bus.bus_addr, addr - (addr % 4)); end
        n_checks++; if (bus.bus_we !== wr) begin n_fail++; $display("FAIL %s bus_we got %b exp %b", tag, bus.bus_we, wr); end
        n_checks++; if (bus.bus_wstrb !== model_strb(wr, f3, addr)) begin n_fail++; $display("FAIL %s bus_wstrb got %b exp %b", tag, bus.bus_wstrb, model_strb(wr, f3, addr)); end
        if (wr) begin
          n_checks++; if (bus.bus_wdata !== model_wdata(f3, sd)) begin n_fail++; $display("FAIL %s bus_wdata got %h exp %h", tag, bus.bus_wdata, model_wdata(f3, sd)); end
        end
      end
      case (phase)
        0: if (drop_left > 0) drop_left--; else phase = 1;
        1: if (bus.bus_req_ready) phase = 2; else rwait++;
        2: if (bus.bus_rsp_valid) begin
             phase = 3;
             if (err) begin fault_exp = 1'b1; if (!wr) ld_exp = '0; end
             else if (!wr) ld_exp = model_load(f3, addr, rdata);
           end else begin
             swait++;
             if (swait == TMO) begin phase = 3; fault_exp = 1'b1; if (!wr) ld_exp = '0; end
           end
        default: ;
      endcase
      @(posedge clock); #1;
      bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0;
      cyc++;
    end
    if (phase != 3) begin
      n_checks++; n_fail++; $display("FAIL %s completion got timeout exp done", tag);
    end
    ld_model = ld_exp;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s done_stall got %b exp 0", tag, stall); end
    n_checks++; if (access_fault !== fault_exp) begin n_fail++; $display("FAIL %s access_fault got %b exp %b", tag, access_fault, fault_exp); end
    n_checks++; if (load_data !== ld_model) begin n_fail++; $display("FAIL %s load_data got %h exp %h", tag, load_data, ld_model); end
    @(posedge clock); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    n_checks++; if (access_fault !== 1'b0) begin n_fail++; $display("FAIL %s fault_pulse got %b exp 0", tag, access_fault); end
    n_checks++; if (bus.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL %s idle_valid got %b exp 0", tag, bus.bus_req_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; address = '0; store_data = '0;
    bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0; bus.bus_rdata = '0; bus.bus_error = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL rst load_data got %h exp 0", load_data); end
    n_checks++; if ({stall, misaligned, access_fault, bus.bus_req_valid, bus.bus_we} !== 5'b0) begin n_fail++; $display("FAIL rst flags got %b exp 00000", {stall, misaligned, access_fault, bus.bus_req_valid, bus.bus_we}); end
    n_checks++; if ({bus.bus_addr, bus.bus_wdata, bus.bus_wstrb} !== '0) begin n_fail++; $display("FAIL rst bus got %h/%h/%b exp 0", bus.bus_addr, bus.bus_wdata, bus.bus_wstrb); end
    #2 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_store_byte();
    run_access(1'b0, 1'b1, F3_B, 32'h103, 32'hAB, 32'h0, 0, 0, 1'b0, 0, "sb");
    n_checks++; if (bus.bus_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb wstrb_const got %b exp 1000", bus.bus_wstrb); end
    n_checks++; if (bus.bus_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL sb wdata_const got %h exp abababab", bus.bus_wdata); end
    n_checks++; if (bus.bus_addr !== 32'h100) begin n_fail++; $display("FAIL sb addr_const got %h exp 100", bus.bus_addr); end
  endtask

  task automatic test_load_extend();
    run_access(1'b1, 1'b0, F3_B, 32'h102, 32'h0, 32'h12803456, 0, 0, 1'b0, 0, "lb");
    n_checks++; if (load_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb const got %h exp ffffff80", load_data); end
    run_access(1'b1, 1'b0, F3_BU, 32'h102, 32'h0, 32'h12803456, 0, 0, 1'b0, 0, "lbu");
    n_checks++; if (load_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu const got %h exp 00000080", load_data); end
    run_access(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h12803456, 0, 0, 1'b0, 0, "lhu");
    n_checks++; if (load_data !== 32'h00001280) begin n_fail++; $display("FAIL lhu const got %h exp 00001280", load_data); end
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, F3_H, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0, 0, "lh_mis");
    run_access(1'b0, 1'b1, F3_W, 32'h202, 32'h1, 32'h0, 0, 0, 1'b0, 0, "sw_mis");
    run_access(1'b0, 1'b1, F3_BU, 32'h200, 32'h1, 32'h0, 0, 0, 1'b0, 0, "sbu_illegal");
    run_access(1'b1, 1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0, 1'b0, 0, "f3_011");
  endtask

  task automatic test_store_stall();
    run_access(1'b0, 1'b1, F3_W, 32'h2C, 32'hDEADBEEF, 32'h0, 3, 1, 1'b0, 0, "sw_stall");
    run_access(1'b1, 1'b1, F3_H, 32'h2E, 32'h0000BEEF, 32'h0, 1, 0, 1'b0, 0, "both_sh");
  endtask

  task automatic test_timeout_drop();
    run_access(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h0, 0, -1, 1'b0, 0, "lw_tmo");
    bus.bus_rsp_valid = 1'b1; bus.bus_error = 1'b1; bus.bus_rdata = 32'h5555AAAA;
    @(posedge clock); #1;
    bus.bus_rsp_valid = 1'b0; bus.bus_error = 1'b0;
    #1;
    n_checks++; if (access_fault !== 1'b0) begin n_fail++; $display("FAIL late_rsp fault got %b exp 0", access_fault); end
    n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL late_rsp load got %h exp 0", load_data); end
    @(posedge clock); #1;
    run_access(1'b1, 1'b0, F3_W, 32'h44, 32'h0, 32'hCAFEF00D, 1, 2, 1'b0, 0, "lw_after_drop");
    n_checks++; if (load_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lw_after_drop const got %h exp cafef00d", load_data); end
    run_access(1'b0, 1'b1, F3_W, 32'h48, 32'h11111111, 32'h0, 0, -1, 1'b0, 0, "sw_tmo");
    run_access(1'b1, 1'b0, F3_H, 32'h4A, 32'h0, 32'h9ABC0000, 0, 0, 1'b0, 3, "lh_wait_drop");
    run_access(1'b1, 1'b0, F3_W, 32'h4C, 32'h0, 32'h01234567, 0, 0, 1'b1, 0, "lw_buserr");
  endtask

  task automatic test_reset_mid();
    run_access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 0, "lw_pre_rst");
    mem_write = 1'b1; funct3 = F3_B; address = 32'h305; store_data = 32'h77;
    bus.bus_req_ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.bus_req_ready = 1'b0;
    mem_write = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid load got %h exp 0", load_data); end
    n_checks++; if ({stall, misaligned, access_fault, bus.bus_req_valid, bus.bus_we} !== 5'b0) begin n_fail++; $display("FAIL rst_mid flags got %b exp 00000", {stall, misaligned, access_fault, bus.bus_req_valid, bus.bus_we}); end
    n_checks++; if ({bus.bus_addr, bus.bus_wdata, bus.bus_wstrb} !== '0) begin n_fail++; $display("FAIL rst_mid bus got %h/%h/%b exp 0", bus.bus_addr, bus.bus_wdata, bus.bus_wstrb); end
    ld_model = '0;
    @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #1;
    run_access(1'b1, 1'b0, F3_W, 32'h308, 32'h0, 32'h600DF00D, 0, 0, 1'b0, 0, "lw_post_rst");
  endtask

  task automatic test_random();
    logic [1:0] rw;
    for (int i = 0; i < 60; i++) begin
      rw = 2'($urandom_range(1, 3));
      run_access(rw[0], rw[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 $urandom_range(0, 7) == 0, 0, $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_extend();
    test_misaligned();
    test_store_stall();
    test_timeout_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

endmodule
